// File: rtl/exp_share_sched.sv
// exp_share_sched: round-robin time-sharing of one combinational Q1.6 exp unit
// between NUM_REQ lanes, with per-lane credit flow control and one registered
// result stage. Optional per-lane softmax row accumulation under `EXP_SUM_EN.
module exp_share_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
`ifdef EXP_SUM_EN
  input  logic [NUM_REQ-1:0]   req_last,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           exp_in,
  input  logic [7:0]           exp_out,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  input  logic [NUM_REQ-1:0]   credit_return,
  output logic                 busy,
`ifdef EXP_SUM_EN
  output logic                 sum_valid,
  output logic [15:0]          sum_data,
`endif
  output logic                 credit_err
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam int unsigned PW = $clog2(NUM_REQ);

  logic [CW-1:0]      credit_q [NUM_REQ];
  logic [CW-1:0]      credit_d [NUM_REQ];
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               credit_err_q, credit_err_d;

  logic [NUM_REQ-1:0] eligible_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [PW-1:0]      grant_idx_c;
  logic               any_grant_c;
  logic [7:0]         exp_in_c;
  logic               busy_c;

`ifdef EXP_SUM_EN
  logic [15:0] acc_q [NUM_REQ];
  logic [15:0] acc_d [NUM_REQ];
  logic        sum_valid_q, sum_valid_d;
  logic [15:0] sum_data_q, sum_data_d;
`endif

  // Round-robin grant: first eligible lane starting at the pointer, with wrap.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    grant_c     = '0;
    grant_idx_c = '0;
    any_grant_c = 1'b0;
    exp_in_c    = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible_c[i] = req_valid[i] & (credit_q[i] != '0);
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PW'((32'(ptr_q) + k) % NUM_REQ);
      if (!any_grant_c && eligible_c[idx]) begin
        any_grant_c  = 1'b1;
        grant_idx_c  = idx;
        grant_c[idx] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) exp_in_c = req_data[8*i +: 8];
    end
  end

  // Next-state: pointer, result stage, credit counters and sticky error.
  always_comb begin
    ptr_d        = ptr_q;
    rsp_valid_d  = grant_c;
    rsp_data_d   = rsp_data_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    busy_c       = |rsp_valid_q;

    if (any_grant_c) begin
      ptr_d      = (grant_idx_c == PW'(NUM_REQ - 1)) ? '0 : grant_idx_c + PW'(1);
      rsp_data_d = exp_out;
    end

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (credit_q[i] != CW'(CREDITS)) busy_c = 1'b1;
      case ({grant_c[i], credit_return[i]})
        2'b10: credit_d[i] = credit_q[i] - CW'(1);
        2'b01: begin
          // A return into a full counter means the downstream accounting is broken.
          if (credit_q[i] == CW'(CREDITS)) credit_err_d = 1'b1;
          else                             credit_d[i]  = credit_q[i] + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef EXP_SUM_EN
  // Per-lane saturating row accumulator; flushed to sum_data on the last term.
  always_comb begin
    logic [16:0] tot;
    logic [15:0] sat;
    tot         = '0;
    sat         = '0;
    acc_d       = acc_q;
    sum_valid_d = 1'b0;
    sum_data_d  = sum_data_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        tot = {1'b0, acc_q[i]} + {9'b0, exp_out};
        sat = tot[16] ? 16'hFFFF : tot[15:0];
        if (req_last[i]) begin
          sum_valid_d = 1'b1;
          sum_data_d  = sat;
          acc_d[i]    = '0;
        end else begin
          acc_d[i]    = sat;
        end
      end
    end
  end
`endif

  // State registers; reset drops any in-flight result and restores credits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      credit_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) credit_q[i] <= CW'(CREDITS);
`ifdef EXP_SUM_EN
      sum_valid_q  <= 1'b0;
      sum_data_q   <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) acc_q[i] <= '0;
`endif
    end else begin
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      credit_err_q <= credit_err_d;
      credit_q     <= credit_d;
`ifdef EXP_SUM_EN
      sum_valid_q  <= sum_valid_d;
      sum_data_q   <= sum_data_d;
      acc_q        <= acc_d;
`endif
    end
  end

  assign req_ready  = grant_c;
  assign exp_in     = exp_in_c;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = busy_c;
  assign credit_err = credit_err_q;
`ifdef EXP_SUM_EN
  assign sum_valid  = sum_valid_q;
  assign sum_data   = sum_data_q;
`endif

endmodule

// File: tb/tb_exp_share_sched.sv
// Directed bench for exp_share_sched with a scoreboard queue of expected
// responses. The exp unit is stubbed as exp_out = exp_in + 1.
module tb_exp_share_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  exp_in;
  logic [7:0]  exp_out;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [3:0]  credit_return;
  logic        busy;
  logic        credit_err;
`ifdef EXP_SUM_EN
  logic [3:0]  req_last;
  logic        sum_valid;
  logic [15:0] sum_data;
  logic        exp_sv;
  logic [15:0] exp_sd;
`endif

  typedef struct packed {
    logic [3:0] lane;
    logic [7:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  assign exp_out = exp_in + 8'h01;

  exp_share_sched #(.NUM_REQ(4), .CREDITS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
`ifdef EXP_SUM_EN
    .req_last      (req_last),
    .sum_valid     (sum_valid),
    .sum_data      (sum_data),
`endif
    .req_ready     (req_ready),
    .exp_in        (exp_in),
    .exp_out       (exp_out),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .credit_return (credit_return),
    .busy          (busy),
    .credit_err    (credit_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One clock: check grant/exp_in after inputs settle, then the registered response.
  task automatic tick(input logic [3:0] er);
    logic [7:0] ed;
    rsp_t       r;
    #1;
    ed = 8'h00;
    for (int i = 0; i < 4; i++) if (er[i]) ed = req_data[8*i +: 8];
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("exp_in", 32'(exp_in), 32'(ed));
    if (er != 4'h0) sb.push_back('{lane: er, data: ed + 8'h01});
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(r.lane));
      chk("rsp_data", 32'(rsp_data), 32'(r.data));
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'h0);
    end
`ifdef EXP_SUM_EN
    chk("sum_valid", 32'(sum_valid), 32'(exp_sv));
    if (exp_sv) chk("sum_data", 32'(sum_data), 32'(exp_sd));
    exp_sv = 1'b0;
`endif
    @(negedge clk);
  endtask

  // Reset applied from a negedge, possibly with a result in flight.
  task automatic do_reset();
    rst           = 1'b1;
    req_valid     = '0;
    credit_return = '0;
`ifdef EXP_SUM_EN
    req_last      = '0;
`endif
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_credit_err", 32'(credit_err), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    req_valid     = '0;
    req_data      = {8'h13, 8'h12, 8'h11, 8'h10};
    credit_return = '0;
`ifdef EXP_SUM_EN
    req_last      = '0;
    exp_sv        = 1'b0;
    exp_sd        = '0;
`endif
    @(negedge clk);
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 5; i++) tick(4'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_credit_err", 32'(credit_err), 32'h0);

    // All lanes valid, returns every cycle: strict rotation 0,1,2,3.
    req_valid     = 4'hF;
    credit_return = 4'hF;
    for (int n = 0; n < 2; n++) begin
      tick(4'b0001); tick(4'b0010); tick(4'b0100); tick(4'b1000);
    end
    chk("rr_busy_inflight", 32'(busy), 32'h1);
    // Non-granted lanes at full credit received returns.
    chk("rr_credit_err", 32'(credit_err), 32'h1);
    do_reset();

    // Lane 2 alone: 4 credits, then stall until a return.
    req_valid = 4'b0100;
    repeat (4) tick(4'b0100);
    tick(4'h0);
    tick(4'h0);
    chk("stall_busy", 32'(busy), 32'h1);
    chk("stall_rsp_hold", 32'(rsp_data), 32'h13);
    credit_return = 4'b0100;
    tick(4'h0);
    credit_return = 4'h0;
    tick(4'b0100);
    tick(4'h0);
    chk("stall_credit_err", 32'(credit_err), 32'h0);
    do_reset();

    // Grant and return together leave lane 1 at 4 credits.
    req_valid     = 4'b0010;
    credit_return = 4'b0010;
    tick(4'b0010);
    credit_return = 4'h0;
    repeat (4) tick(4'b0010);
    tick(4'h0);
    chk("both_credit_err", 32'(credit_err), 32'h0);
    do_reset();

    // Return at full credit: sticky error, counter stays at 4.
    credit_return = 4'b0001;
    tick(4'h0);
    credit_return = 4'h0;
    tick(4'h0);
    chk("over_credit_err", 32'(credit_err), 32'h1);
    req_valid = 4'b0001;
    repeat (4) tick(4'b0001);
    tick(4'h0);
    chk("over_credit_err_sticky", 32'(credit_err), 32'h1);
    do_reset();

    // Sparse requesters: pointer skips idle lanes.
    req_valid     = 4'b1010;
    credit_return = 4'b1010;
    tick(4'b0010); tick(4'b1000); tick(4'b0010); tick(4'b1000);
    do_reset();

`ifdef EXP_SUM_EN
    // Row of three 8'h40 terms sums to 16'h00C0; the next row starts at zero.
    req_data  = {8'h13, 8'h12, 8'h11, 8'h3F};
    req_valid = 4'b0001;
    tick(4'b0001);
    tick(4'b0001);
    req_last = 4'b0001;
    exp_sv   = 1'b1;
    exp_sd   = 16'h00C0;
    tick(4'b0001);
    req_last  = 4'b0000;
    req_valid = 4'b0000;
    tick(4'h0);
    req_valid     = 4'b0001;
    req_last      = 4'b0001;
    credit_return = 4'b0001;
    exp_sv        = 1'b1;
    exp_sd        = 16'h0040;
    tick(4'b0001);
    req_valid     = 4'b0000;
    req_last      = 4'b0000;
    credit_return = 4'b0000;
    tick(4'h0);
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
